// File: rtl/csr_trap_sequencer.sv
// Owns the machine-mode CSR port: sequences ecall (7 cycles) and mret (5 cycles) side effects and emits a PC redirect.
// Instruction CSR requests pass through only in IDLE with no trap pending; otherwise gnt=0 and busy stalls the core.
module csr_trap_sequencer #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_valid,
  input  logic        mret_valid,
  input  logic [31:0] trap_pc,
  input  logic [11:0] csr_req_addr,
  input  logic [1:0]  csr_req_wen,
  input  logic [31:0] csr_req_wdata,
  output logic        csr_req_gnt,
  output logic [31:0] csr_req_rdata,
  output logic [11:0] csr_addr,
  output logic [1:0]  csr_wen,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [1:0]  WEN_NONE     = 2'b00;
  localparam logic [1:0]  WEN_WRITE    = 2'b01;

  typedef enum logic [3:0] {
    IDLE, EC_EPC, EC_CAUSE, EC_RSTAT, EC_WSTAT, EC_TVEC,
    MR_RSTAT, MR_WSTAT, MR_EPC, REDIR
  } state_t;

  state_t      state;
  logic [31:0] tmp;
  logic [31:0] epc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      tmp            <= 32'h0;
      epc_q          <= 32'h0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ecall_valid) begin
            epc_q <= trap_pc;
            state <= EC_EPC;
          end else if (mret_valid) begin
            state <= MR_RSTAT;
          end
        end
        EC_EPC:   state <= EC_CAUSE;
        EC_CAUSE: state <= EC_RSTAT;
        EC_RSTAT: begin
          tmp   <= csr_rdata;
          state <= EC_WSTAT;
        end
        EC_WSTAT: state <= EC_TVEC;
        EC_TVEC: begin
          // Only direct mode is supported, so the mode bits are simply dropped.
          redirect_pc    <= {csr_rdata[31:2], 2'b00};
          redirect_valid <= 1'b1;
          state          <= REDIR;
        end
        MR_RSTAT: begin
          tmp   <= csr_rdata;
          state <= MR_WSTAT;
        end
        MR_WSTAT: state <= MR_EPC;
        MR_EPC: begin
          redirect_pc    <= csr_rdata;
          redirect_valid <= 1'b1;
          state          <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The port is quiet while rst is high so an aborted sequence cannot land a write.
  always_comb begin
    csr_addr    = 12'h0;
    csr_wen     = WEN_NONE;
    csr_wdata   = 32'h0;
    csr_req_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!ecall_valid && !mret_valid) begin
            csr_req_gnt = 1'b1;
            csr_addr    = csr_req_addr;
            csr_wen     = csr_req_wen;
            csr_wdata   = csr_req_wdata;
          end
        end
        EC_EPC: begin
          csr_addr  = ADDR_MEPC;
          csr_wen   = WEN_WRITE;
          csr_wdata = epc_q;
        end
        EC_CAUSE: begin
          csr_addr  = ADDR_MCAUSE;
          csr_wen   = WEN_WRITE;
          csr_wdata = MCAUSE_ECALL;
        end
        EC_RSTAT, MR_RSTAT: csr_addr = ADDR_MSTATUS;
        EC_WSTAT: begin
          csr_addr         = ADDR_MSTATUS;
          csr_wen          = WEN_WRITE;
          csr_wdata        = tmp;
          csr_wdata[7]     = tmp[3];
          csr_wdata[3]     = 1'b0;
          csr_wdata[12:11] = 2'b11;
        end
        MR_WSTAT: begin
          csr_addr         = ADDR_MSTATUS;
          csr_wen          = WEN_WRITE;
          csr_wdata        = tmp;
          csr_wdata[3]     = tmp[7];
          csr_wdata[7]     = 1'b1;
          csr_wdata[12:11] = 2'b11;
        end
        EC_TVEC: csr_addr = ADDR_MTVEC;
        MR_EPC:  csr_addr = ADDR_MEPC;
        default: ;
      endcase
    end
  end

  assign csr_req_rdata = csr_rdata;
  assign busy          = (state != IDLE) | ecall_valid | mret_valid;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Randomized bench for csr_trap_sequencer with a CSR file model, a write/redirect scoreboard and a spec-level reference.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst, ecall_valid, mret_valid;
  logic [31:0] trap_pc;
  logic [11:0] csr_req_addr;
  logic [1:0]  csr_req_wen;
  logic [31:0] csr_req_wdata;
  logic        csr_req_gnt;
  logic [31:0] csr_req_rdata;
  logic [11:0] csr_addr;
  logic [1:0]  csr_wen;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .mret_valid(mret_valid),
    .trap_pc(trap_pc), .csr_req_addr(csr_req_addr), .csr_req_wen(csr_req_wen),
    .csr_req_wdata(csr_req_wdata), .csr_req_gnt(csr_req_gnt), .csr_req_rdata(csr_req_rdata),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // CSR file: index 0 mstatus, 1 mtvec, 2 mepc, 3 mcause, 4 sink for other addresses.
  function automatic int idx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return 4;
    endcase
  endfunction

  logic [31:0] csr_file [5];
  logic [31:0] ref_csr  [5];
  logic        file_clr;

  assign csr_rdata = (idx(csr_addr) == 4) ? 32'h0 : csr_file[idx(csr_addr)];

  always @(posedge clk) begin
    if (file_clr) begin
      for (int i = 0; i < 5; i++) csr_file[i] <= 32'h0;
    end else if (csr_wen == 2'b01) begin
      csr_file[idx(csr_addr)] <= csr_wdata;
    end else if (csr_wen == 2'b10) begin
      csr_file[idx(csr_addr)] <= csr_file[idx(csr_addr)] | csr_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {int cyc; logic [11:0] addr; logic [1:0] wen; logic [31:0] data;} wr_t;
  typedef struct {int cyc; logic [31:0] pc;} rd_t;
  wr_t wq[$];
  rd_t rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every port write and every redirect must match the next scoreboard entry.
  always @(negedge clk) begin
    wr_t e;
    rd_t r;
    if (csr_wen != 2'b00) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h wen %b data %h, expected no write (cycle %0d)",
                 csr_addr, csr_wen, csr_wdata, cyc);
      end else begin
        e = wq.pop_front();
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        check("wr_addr", 32'(csr_addr), 32'(e.addr));
        check("wr_wen", 32'(csr_wen), 32'(e.wen));
        check("wr_data", csr_wdata, e.data);
      end
    end
    if (redirect_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc %h, expected no redirect (cycle %0d)", redirect_pc, cyc);
      end else begin
        r = rq.pop_front();
        check("redir_cycle", 32'(cyc), 32'(r.cyc));
        check("redir_pc", redirect_pc, r.pc);
      end
    end
  end

  // Reference rules for mstatus updates.
  function automatic logic [31:0] ec_stat(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | (s[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mr_stat(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1880 | (s[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [11:0] rand_addr();
    case ($urandom % 4)
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      default: return 12'h342;
    endcase
  endfunction

  task automatic push_wr(input int c, input logic [11:0] a, input logic [1:0] w, input logic [31:0] d);
    wr_t e;
    e.cyc = c; e.addr = a; e.wen = w; e.data = d;
    wq.push_back(e);
  endtask

  // One instruction CSR access in IDLE.
  task automatic idle_req(input logic [11:0] a, input logic [1:0] w, input logic [31:0] d);
    logic [31:0] old;
    @(posedge clk); #1;
    ecall_valid = 1'b0; mret_valid = 1'b0;
    csr_req_addr = a; csr_req_wen = w; csr_req_wdata = d;
    old = ref_csr[idx(a)];
    if (w == 2'b01) begin
      push_wr(cyc, a, w, d);
      ref_csr[idx(a)] = d;
    end else if (w == 2'b10) begin
      push_wr(cyc, a, w, d);
      ref_csr[idx(a)] = old | d;
    end
    @(negedge clk);
    check("idle_gnt", 32'(csr_req_gnt), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rdata", csr_req_rdata, old);
  endtask

  // One trap; r != 0 asserts rst during relative cycle r.
  task automatic trap(input bit is_ec, input bit both, input logic [31:0] pc, input int r,
                      input logic [11:0] a0, input logic [1:0] w0, input logic [31:0] d0);
    int c, last;
    rd_t rd;
    logic [31:0] s;
    @(posedge clk); #1;
    c = cyc;
    ecall_valid = is_ec;
    mret_valid = is_ec ? both : 1'b1;
    trap_pc = pc;
    csr_req_addr = a0; csr_req_wen = w0; csr_req_wdata = d0;
    last = is_ec ? 6 : 4;
    if (is_ec) begin
      if (r == 0 || r > 1) begin push_wr(c + 1, 12'h341, 2'b01, pc); ref_csr[2] = pc; end
      if (r == 0 || r > 2) begin push_wr(c + 2, 12'h342, 2'b01, 32'd11); ref_csr[3] = 32'd11; end
      if (r == 0 || r > 4) begin s = ec_stat(ref_csr[0]); push_wr(c + 4, 12'h300, 2'b01, s); ref_csr[0] = s; end
      if (r == 0) begin rd.cyc = c + 6; rd.pc = ref_csr[1] & ~32'h3; rq.push_back(rd); end
    end else begin
      if (r == 0 || r > 2) begin s = mr_stat(ref_csr[0]); push_wr(c + 2, 12'h300, 2'b01, s); ref_csr[0] = s; end
      if (r == 0) begin rd.cyc = c + 4; rd.pc = ref_csr[2]; rq.push_back(rd); end
    end
    for (int k = 0; k <= ((r == 0) ? last : r); k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        ecall_valid = 1'b0; mret_valid = 1'b0;
        rst = (k == r);
        csr_req_addr = rand_addr();
        csr_req_wen = 2'($urandom_range(0, 2));
        csr_req_wdata = $urandom;
        if (is_ec && k == 5) csr_req_wen = 2'b10;
      end
      @(negedge clk);
      if (k != r) check("trap_busy", 32'(busy), 32'd1);
      check("trap_gnt", 32'(csr_req_gnt), 32'd0);
    end
    if (r != 0) begin
      @(posedge clk); #1;
      rst = 1'b0;
      csr_req_wen = 2'b00;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gnt", 32'(csr_req_gnt), 32'd1);
      check("rst_redir", 32'(redirect_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] saved;
    file_clr = 1'b1;
    rst = 1'b1; ecall_valid = 1'b0; mret_valid = 1'b0; trap_pc = 32'h0;
    csr_req_addr = 12'h0; csr_req_wen = 2'b00; csr_req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) ref_csr[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    file_clr = 1'b0;
    @(negedge clk);
    check("reset_redir_valid", 32'(redirect_valid), 32'd0);
    check("reset_redir_pc", redirect_pc, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt", 32'(csr_req_gnt), 32'd1);

    // Ecall then mret.
    idle_req(12'h305, 2'b01, 32'h8000_0100);
    idle_req(12'h300, 2'b01, 32'h0000_0008);
    trap(1'b1, 1'b0, 32'h8000_0040, 0, 12'h0, 2'b00, 32'h0);
    idle_req(12'h300, 2'b00, 32'h0);
    check("ecall_mepc", csr_file[2], 32'h8000_0040);
    check("ecall_mcause", csr_file[3], 32'h0000_000B);
    check("ecall_mstatus", csr_file[0], 32'h0000_1880);
    check("ecall_redir_pc", redirect_pc, 32'h8000_0100);
    trap(1'b0, 1'b0, 32'h0, 0, 12'h0, 2'b00, 32'h0);
    idle_req(12'h341, 2'b00, 32'h0);
    check("mret_mstatus", csr_file[0], 32'h0000_1888);
    check("mret_redir_pc", redirect_pc, 32'h8000_0040);

    // mtvec mode bits masked.
    idle_req(12'h305, 2'b01, 32'h8000_0103);
    trap(1'b1, 1'b0, 32'h8000_0080, 0, 12'h0, 2'b00, 32'h0);
    check("mask_redir_pc", redirect_pc, 32'h8000_0100);

    // Same-cycle ecall and instruction write to mcause.
    trap(1'b1, 1'b0, 32'h8000_00C0, 0, 12'h342, 2'b01, 32'h55);
    idle_req(12'h342, 2'b00, 32'h0);
    check("arb_mcause", csr_file[3], 32'h0000_000B);

    // Ecall and mret together: ecall wins.
    trap(1'b1, 1'b1, 32'h8000_0200, 0, 12'h0, 2'b00, 32'h0);
    idle_req(12'h341, 2'b00, 32'h0);
    check("both_mepc", csr_file[2], 32'h8000_0200);

    // Reset during EC_WSTAT.
    idle_req(12'h342, 2'b01, 32'h0);
    saved = ref_csr[0];
    trap(1'b1, 1'b0, 32'h8000_0300, 4, 12'h0, 2'b00, 32'h0);
    check("rst_mepc", csr_file[2], 32'h8000_0300);
    check("rst_mcause", csr_file[3], 32'h0000_000B);
    check("rst_mstatus", csr_file[0], saved);

    // Random mix.
    for (int n = 0; n < 80; n++) begin
      case ($urandom % 6)
        0, 1: idle_req(rand_addr(), 2'($urandom_range(0, 2)), $urandom);
        2: trap(1'b1, 1'($urandom % 2), $urandom, 0, rand_addr(), 2'($urandom_range(0, 2)), $urandom);
        3: trap(1'b0, 1'b0, 32'h0, 0, rand_addr(), 2'($urandom_range(0, 2)), $urandom);
        4: trap(1'b1, 1'b0, $urandom, int'($urandom_range(1, 5)), rand_addr(), 2'($urandom_range(0, 2)), $urandom);
        default: trap(1'b0, 1'b0, 32'h0, int'($urandom_range(1, 3)), rand_addr(), 2'($urandom_range(0, 2)), $urandom);
      endcase
    end

    idle_req(12'h300, 2'b00, 32'h0);
    idle_req(12'h305, 2'b00, 32'h0);
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    for (int i = 0; i < 4; i++) check("final_csr", csr_file[i], ref_csr[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
